sra_controller: RTL and testbench
=================================

Name: sra_controller

Overview:
- Control FSM directly upstream of the 16-bit SRA datapath.
- Sequences the datapath through the square-root approximation sqrt(a²+b²) ≈ max(x, x − x/8 + y/2), where x = max(|a|,|b|) and y = min(|a|,|b|).
- Drives the datapath's 21-bit control word and reads back four sign/status bits.
- Provides a start/busy/done handshake to the surrounding system.

Parameters:
- None. The state encoding is internal, and the control-word layout below is fixed.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  begin a computation; sampled only in IDLE
- r1_msb  input  1  bit 15 of datapath R1
- r2_msb  input  1  bit 15 of datapath R2
- au1_msb  input  1  bit 15 of AU1 output (combinational)
- au2_msb  input  1  bit 15 of AU2 output (combinational)
- ctrl_word  output  21  datapath control
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse; result valid on datapath Out in this cycle

Behaviour:
- Single clock domain, clk. Reset is synchronous and active-high on rst.
- Reset, including mid-operation: state <= IDLE, swap flag <= 0. ctrl_word, busy and done are all 0 in IDLE.
- ctrl_word layout:
  - [20] reserved, always 0
  - [19:15] {W_R5,W_R4,W_R3,W_R2,W_R1}
  - [14:5] {s1_AAU2,s0_AAU2,s1_R5,s0_R5,s1_BAU1,s0_BAU1,s1_R2,s0_R2,s1_R1,s0_R1}
  - [4:1] {ctrl_AU2,ctrl_AU1}
  - [0] O_Enable
- AU1 codes: 00 pass A, 01 negate B, 10 A−B, 11 pass B.
- AU2 codes: 00 pass A, 01 pass B, 10 A−B, 11 A+B.
- All selects and AU codes are decoded from the state only. Write enables may also depend on status inputs. This ordering prevents a combinational loop through au1_msb/au2_msb.
- Every select or enable not listed for a state is 0.
- States, one cycle each unless noted:
  - IDLE: waits. start=1 -> LOAD.
  - LOAD: s0_R1, s0_R2, W_R1, W_R2 (R1<=In1, R2<=In2).
  - ABS1: s0_BAU1, AU1=01, s1_R1; W_R1 = r1_msb.
  - ABS2: s1_BAU1, AU1=01, s1_R2; W_R2 = r2_msb.
  - CMP: s1_BAU1, AU1=10; swap <= au1_msb (R1<R2, so x=R2).
  - HALF: W_R3 (R3 <= y>>1).
    - swap=0: s1_BAU1, AU1=11.
    - swap=1: AU1=00.
  - XREG: W_R4, s0_R5, W_R5 (R4 <= x, R5 <= x>>3).
    - swap=0: AU1=00.
    - swap=1: s1_BAU1, AU1=11.
  - SUB: s0_AAU2, AU2=10, s1_R5, W_R5 (R5 <= x − x/8).
  - ADD: s1_AAU2, AU2=11, s1_R5, W_R5 (R5 += y/2).
  - MAX: s0_AAU2, AU2=10 (compare R4−R5). If au2_msb=0, switch to AU2=00 and W_R5 (R5<=R4).
  - DONE: O_Enable=1, done=1 -> IDLE.
- MAX detail: the AU2 code is state-only, so the final select/write is implemented as two sub-cycles MAX_C then MAX_W.
  - MAX_C: AU2=10, capture ge <= ~au2_msb.
  - MAX_W: AU2=00, s0_AAU2, s1_R5, W_R5 = ge.
  - Total MAX cost is 2 cycles.
- Latency: start sampled high at edge N gives LOAD in cycle N+1, and done is high during cycle N+11.
- Handshake:
  - start is ignored while busy=1, including in the DONE cycle.
  - A start held high is re-accepted in the IDLE cycle after DONE.
  - busy=1 from LOAD through DONE inclusive.
- Arithmetic is 16-bit two's complement, modulo 2^16, with no saturation.
- |−32768| wraps to −32768.
- The result is meaningful only for |a|,|b| ≤ 16383.
- Zero inputs produce 0.

Test Plan:
- Reset then In1=3, In2=4, pulse start -> done in cycle N+11, Out=5; busy high for exactly 11 cycles.
- In1=−12 (0xFFF4), In2=5 -> W_R1 asserted in ABS1, W_R2 not asserted in ABS2; Out=13.
- In1=0, In2=−40 -> swap=1, XREG uses AU1=11; SUB gives 35, MAX selects R4; Out=40.
- In1=100, In2=0 -> R5=88 after ADD, ge=1, Out=100. Then In1=In2=0 -> Out=0.
- start held high continuously -> back-to-back runs separated by exactly one IDLE cycle; start pulses during busy are ignored.
- rst asserted in SUB state -> next cycle state IDLE, ctrl_word=0, busy=0, done=0; a new start then completes normally (3,4 -> 5).

Source files
------------

// File: rtl/sra_controller.sv
// sra_controller -- control FSM for the 16-bit SRA datapath.
// Sequences the datapath through sqrt(a^2+b^2) ~= max(x, x - x/8 + y/2),
// x = max(|a|,|b|), y = min(|a|,|b|).
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             begin a computation (sampled only in IDLE)
//   r1_msb, r2_msb    sign bits of datapath R1 / R2
//   au1_msb, au2_msb  sign bits of the combinational AU1 / AU2 outputs
//   ctrl_word[20:0]   datapath control word
//   busy              high in every state except IDLE
//   done              one-cycle pulse, datapath Out valid in this cycle
module sra_controller (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        r1_msb,
    input  logic        r2_msb,
    input  logic        au1_msb,
    input  logic        au2_msb,
    output logic [20:0] ctrl_word,
    output logic        busy,
    output logic        done
);

    typedef enum logic [3:0] {
        IDLE, LOAD, ABS1, ABS2, CMP, HALF, XREG, SUB, ADD, MAX_C, MAX_W, DONE
    } state_t;

    // Field order matches the datapath's control-word bit layout, MSB first.
    typedef struct packed {
        logic       rsvd;
        logic       w_r5, w_r4, w_r3, w_r2, w_r1;
        logic       s1_aau2, s0_aau2, s1_r5, s0_r5, s1_bau1, s0_bau1;
        logic       s1_r2, s0_r2, s1_r1, s0_r1;
        logic [1:0] au2;
        logic [1:0] au1;
        logic       o_en;
    } ctrl_t;

    localparam logic [1:0] AU1_PASS_A = 2'b00, AU1_NEG_B = 2'b01,
                           AU1_SUB    = 2'b10, AU1_PASS_B = 2'b11;
    localparam logic [1:0] AU2_PASS_A = 2'b00, AU2_SUB = 2'b10, AU2_ADD = 2'b11;

    state_t state, state_nxt;
    logic   swap, swap_nxt;   // 1: R2 holds x, R1 holds y
    logic   ge, ge_nxt;       // R4 >= R5, captured in MAX_C
    ctrl_t  cw;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            swap  <= 1'b0;
            ge    <= 1'b0;
        end else begin
            state <= state_nxt;
            swap  <= swap_nxt;
            ge    <= ge_nxt;
        end
    end

    // Selects and AU codes depend on state only; only write enables (and the
    // swap/ge captures) look at status bits, so no loop through au*_msb.
    always_comb begin
        state_nxt = state;
        swap_nxt  = swap;
        ge_nxt    = ge;
        cw        = '0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = LOAD;
            end
            LOAD: begin
                cw.s0_r1 = 1'b1; cw.s0_r2 = 1'b1;
                cw.w_r1  = 1'b1; cw.w_r2  = 1'b1;
                state_nxt = ABS1;
            end
            ABS1: begin
                cw.s0_bau1 = 1'b1; cw.au1 = AU1_NEG_B; cw.s1_r1 = 1'b1;
                cw.w_r1    = r1_msb;
                state_nxt  = ABS2;
            end
            ABS2: begin
                cw.s1_bau1 = 1'b1; cw.au1 = AU1_NEG_B; cw.s1_r2 = 1'b1;
                cw.w_r2    = r2_msb;
                state_nxt  = CMP;
            end
            CMP: begin
                cw.s1_bau1 = 1'b1; cw.au1 = AU1_SUB;
                swap_nxt   = au1_msb;   // R1 - R2 < 0 -> x lives in R2
                state_nxt  = HALF;
            end
            HALF: begin
                cw.w_r3 = 1'b1;         // R3 <= y >> 1
                if (!swap) begin
                    cw.s1_bau1 = 1'b1; cw.au1 = AU1_PASS_B;
                end else begin
                    cw.au1 = AU1_PASS_A;
                end
                state_nxt = XREG;
            end
            XREG: begin
                cw.w_r4 = 1'b1; cw.s0_r5 = 1'b1; cw.w_r5 = 1'b1;
                if (!swap) begin
                    cw.au1 = AU1_PASS_A;
                end else begin
                    cw.s1_bau1 = 1'b1; cw.au1 = AU1_PASS_B;
                end
                state_nxt = SUB;
            end
            SUB: begin
                cw.s0_aau2 = 1'b1; cw.au2 = AU2_SUB; cw.s1_r5 = 1'b1; cw.w_r5 = 1'b1;
                state_nxt  = ADD;
            end
            ADD: begin
                cw.s1_aau2 = 1'b1; cw.au2 = AU2_ADD; cw.s1_r5 = 1'b1; cw.w_r5 = 1'b1;
                state_nxt  = MAX_C;
            end
            MAX_C: begin
                cw.s0_aau2 = 1'b1; cw.au2 = AU2_SUB;
                ge_nxt     = ~au2_msb;
                state_nxt  = MAX_W;
            end
            MAX_W: begin
                cw.s0_aau2 = 1'b1; cw.au2 = AU2_PASS_A; cw.s1_r5 = 1'b1;
                cw.w_r5    = ge;
                state_nxt  = DONE;
            end
            DONE: begin
                cw.o_en   = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                busy      = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    assign ctrl_word = cw;

endmodule

// File: tb/tb_sra_controller.sv
// Directed bench for sra_controller with a small behavioural model of the
// SRA datapath (registers R1..R5, AU1, AU2) closing the status loop.
module tb_sra_controller;

    logic        clk, rst, start;
    logic        r1_msb, r2_msb, au1_msb, au2_msb;
    logic [20:0] ctrl_word;
    logic        busy, done;

    int checks = 0;
    int errors = 0;

    sra_controller dut (
        .clk(clk), .rst(rst), .start(start),
        .r1_msb(r1_msb), .r2_msb(r2_msb), .au1_msb(au1_msb), .au2_msb(au2_msb),
        .ctrl_word(ctrl_word), .busy(busy), .done(done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- datapath model ----------------
    logic [15:0] in1, in2;
    logic [15:0] r1, r2, r3, r4, r5;
    logic [15:0] a1, b1, au1, a2, au2;

    always_comb begin
        a1 = r1;
        b1 = ctrl_word[9] ? r1 : (ctrl_word[10] ? r2 : 16'h0);
        case (ctrl_word[2:1])
            2'b00:   au1 = a1;
            2'b01:   au1 = 16'h0 - b1;
            2'b10:   au1 = a1 - b1;
            default: au1 = b1;
        endcase
        a2 = ctrl_word[13] ? r4 : (ctrl_word[14] ? r3 : 16'h0);
        case (ctrl_word[4:3])
            2'b00:   au2 = a2;
            2'b01:   au2 = r5;
            2'b10:   au2 = a2 - r5;
            default: au2 = a2 + r5;
        endcase
    end

    assign r1_msb  = r1[15];
    assign r2_msb  = r2[15];
    assign au1_msb = au1[15];
    assign au2_msb = au2[15];

    always @(posedge clk) begin
        if (ctrl_word[15]) r1 <= ctrl_word[5] ? in1 : au1;
        if (ctrl_word[16]) r2 <= ctrl_word[7] ? in2 : au1;
        if (ctrl_word[17]) r3 <= au1 >> 1;
        if (ctrl_word[18]) r4 <= au1;
        if (ctrl_word[19]) r5 <= ctrl_word[11] ? (au1 >> 3) : au2;
    end

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, obs, exp);
        end
    endtask

    logic [20:0] cw_log [0:15];

    // Entered at a negedge with DUT in IDLE; returns at the negedge of DONE.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          output int cycles, output logic [15:0] out_v);
        bit got;
        got    = 0;
        cycles = 0;
        out_v  = 16'h0;
        in1 = a; in2 = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (k < 16) cw_log[k] = ctrl_word;
            if (busy) cycles++;
            if (done) begin
                out_v = ctrl_word[0] ? r5 : 16'hDEAD;
                got   = 1;
                break;
            end
            @(negedge clk);
        end
        if (!got) chk("done_timeout", 0, 1);
    endtask

    int          cyc;
    logic [15:0] outv;
    logic [23:0] bhist;
    int          ndone;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; in1 = 16'h0; in2 = 16'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_cw",   {11'd0, ctrl_word}, 32'h0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);

        // 3,4 -> 5 with the full control-word trace
        run_op(16'd3, 16'd4, cyc, outv);
        chk("34_busy_cycles", cyc, 11);
        chk("34_out", {16'd0, outv}, 32'd5);
        chk("34_load", {11'd0, cw_log[0]},  32'h180A0);
        chk("34_abs1", {11'd0, cw_log[1]},  32'h00242);
        chk("34_abs2", {11'd0, cw_log[2]},  32'h00502);
        chk("34_cmp",  {11'd0, cw_log[3]},  32'h00404);
        chk("34_half", {11'd0, cw_log[4]},  32'h20000);
        chk("34_xreg", {11'd0, cw_log[5]},  32'hC0C06);
        chk("34_sub",  {11'd0, cw_log[6]},  32'h83010);
        chk("34_add",  {11'd0, cw_log[7]},  32'h85018);
        chk("34_maxc", {11'd0, cw_log[8]},  32'h02010);
        chk("34_maxw", {11'd0, cw_log[9]},  32'h03000);
        chk("34_done", {11'd0, cw_log[10]}, 32'h00001);
        @(negedge clk);
        chk("34_idle_busy", {31'd0, busy}, 32'd0);

        // -12,5 -> 13; R1 negated, R2 left alone
        run_op(16'hFFF4, 16'd5, cyc, outv);
        chk("m12_out",  {16'd0, outv}, 32'd13);
        chk("m12_abs1", {11'd0, cw_log[1]}, 32'h08242);
        chk("m12_abs2", {11'd0, cw_log[2]}, 32'h00502);
        chk("m12_half", {11'd0, cw_log[4]}, 32'h20406);
        chk("m12_xreg", {11'd0, cw_log[5]}, 32'hC0800);
        @(negedge clk);

        // 0,-40 -> 40; swap path, MAX picks R4
        run_op(16'd0, 16'hFFD8, cyc, outv);
        chk("m40_out",  {16'd0, outv}, 32'd40);
        chk("m40_abs2", {11'd0, cw_log[2]}, 32'h10502);
        chk("m40_half", {11'd0, cw_log[4]}, 32'h20000);
        chk("m40_xreg", {11'd0, cw_log[5]}, 32'hC0C06);
        chk("m40_maxw", {11'd0, cw_log[9]}, 32'h83000);
        @(negedge clk);

        // 100,0 -> 100; then zeros -> 0
        run_op(16'd100, 16'd0, cyc, outv);
        chk("100_out",  {16'd0, outv}, 32'd100);
        chk("100_maxw", {11'd0, cw_log[9]}, 32'h83000);
        @(negedge clk);
        run_op(16'd0, 16'd0, cyc, outv);
        chk("zero_out", {16'd0, outv}, 32'd0);
        @(negedge clk);

        // start held high: two runs with exactly one IDLE cycle between
        in1 = 16'd3; in2 = 16'd4; start = 1'b1;
        ndone = 0;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            bhist[k] = busy;
            if (done) ndone++;
            if (k == 23) start = 1'b0;
        end
        chk("b2b_busy_hist", {8'd0, bhist}, 32'h7FF7FF);
        chk("b2b_done_count", ndone, 2);
        @(negedge clk);
        chk("b2b_idle_after", {31'd0, busy}, 32'd0);

        // reset in SUB, then a normal run
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        chk("rstmid_in_sub", {11'd0, ctrl_word}, 32'h83010);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstmid_cw",   {11'd0, ctrl_word}, 32'h0);
        chk("rstmid_busy", {31'd0, busy}, 32'd0);
        chk("rstmid_done", {31'd0, done}, 32'd0);
        run_op(16'd3, 16'd4, cyc, outv);
        chk("rstmid_cycles", cyc, 11);
        chk("rstmid_out", {16'd0, outv}, 32'd5);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
